// File: rtl/dma_counter.sv
`default_nettype none
// ============================================================================
// Module   : dma_counter
// Brief    : Loadable up/down binary counter with count enable and a
//            terminal-count carry/borrow output. It is the word/address
//            counting element of an Am2940-style DMA generator, cascadable
//            through carry_out. Clear is asynchronous; load/count/hold are
//            synchronous to clk.
// Revision : 1.0 - initial release
// ============================================================================
module dma_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_out,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] c_ZERO     = '0;
  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_count_en;
  logic             w_terminal;

  // Counting only happens when enabled and no load is pending (load wins).
  assign w_count_en = enable & ~load;

  // Terminal value depends on direction: all-ones going up, zero going down.
  assign w_terminal = up ? (r_count == c_ALL_ONES) : (r_count == c_ZERO);

  // Next-state selection: load, then count, otherwise hold.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = data_in;
    end else if (enable) begin
      w_next = up ? (r_count + c_ONE) : (r_count - c_ONE);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_count <= c_ZERO;
    end else begin
      r_count <= w_next;
    end
  end

  assign count_out = r_count;

  // Carry/borrow: high in the cycle whose next edge wraps; forced low in reset.
  assign carry_out = ~res & w_count_en & w_terminal;

`ifndef SYNTHESIS
  // Unknown control inputs outside reset leave the counter in an invalid state.
  a_ctrl_known : assert property (@(posedge clk) disable iff (res)
                                  !$isunknown({load, enable}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_counter
// Brief    : Scoreboard bench for dma_counter: directed sequence followed by
//            randomized traffic, checked against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         res;
  logic         load;
  logic         enable;
  logic         up;
  logic [W-1:0] data_in;
  logic [W-1:0] count_out;
  logic         carry_out;

  typedef struct {
    int count;
    bit carry;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_count = 0;

  dma_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .res       (res),
    .load      (load),
    .enable    (enable),
    .up        (up),
    .data_in   (data_in),
    .count_out (count_out),
    .carry_out (carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs shortly after a rising edge and record what the
  // outputs must show for the rest of that cycle.
  task automatic step(input bit r, input bit l, input bit e, input bit u,
                      input logic [W-1:0] d);
    exp_t item;
    @(posedge clk);
    #2;
    res = r; load = l; enable = e; up = u; data_in = d;
    if (r) begin
      model_count = 0;
      item.count = 0;
      item.carry = 1'b0;
    end else begin
      item.count = model_count;
      // Carry/borrow exactly when the pending count leaves the 0..MOD-1 range.
      item.carry = e && !l && (u ? (model_count + 1 >= MOD) : (model_count - 1 < 0));
      if (l)      model_count = int'(d);
      else if (e) model_count = u ? (model_count + 1) % MOD
                                  : (model_count - 1 + MOD) % MOD;
    end
    exp_q.push_back(item);
  endtask

  // Monitor: mid-cycle, compare outputs with the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #7;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (int'(count_out) != e.count) begin
          bad++;
          $display("FAIL count_out at %0t: got %0d expected %0d", $time, count_out, e.count);
        end
        total++;
        if (carry_out !== e.carry) begin
          bad++;
          $display("FAIL carry_out at %0t: got %b expected %b (count %0d)",
                   $time, carry_out, e.carry, count_out);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    res = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; data_in = '0;

    // Reset state, then load 1010 and clear it asynchronously.
    step(1, 0, 0, 1, 4'b0000);
    step(0, 0, 0, 1, 4'b0000);
    step(0, 1, 0, 1, 4'b1010);
    step(0, 0, 0, 1, 4'b0000);
    step(1, 0, 0, 1, 4'b0000);
    step(0, 0, 0, 1, 4'b0000);
    step(0, 0, 0, 1, 4'b0000);
    // Load then count up three.
    step(0, 1, 0, 1, 4'b1010);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'b0000);
    // Count down five.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 4'b0000);
    // Hold with data_in ignored.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 4'b1111);
    // Load 1101 and wrap up.
    step(0, 1, 0, 1, 4'b1101);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'b0000);
    // Wrap down from 0000.
    step(0, 0, 1, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0000);
    // Load beats enable.
    step(0, 1, 1, 0, 4'b0011);
    step(0, 0, 0, 0, 4'b0000);
    // Reset mid-count with load/enable also high.
    step(0, 0, 1, 1, 4'b0000);
    step(1, 1, 1, 1, 4'b0111);
    step(0, 0, 1, 1, 4'b0000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           W'($urandom_range(0, MOD - 1)));
    end
    step(0, 0, 0, 1, 4'b0000);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #8;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
